// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: sample FIFO feeding a DAC7611 serializer at a programmable
// rate. A free-running divider produces sample ticks; each tick either loads the
// FIFO head into the output register, flags underflow on an empty FIFO, or counts
// an overrun when the previous sample has not yet been taken.
// Optional feature: define DAC_FEEDER_RAMP_TEST_EN to add the ramp_mode input,
// which replaces FIFO data with an incrementing test ramp on each tick.
module dac_sample_feeder #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef DAC_FEEDER_RAMP_TEST_EN
  input  logic                   ramp_mode,
`endif
  input  logic                   wr_en,
  input  logic [11:0]            wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  input  logic [DIV_W-1:0]       rate_div,
  output logic [11:0]            dac_code,
  output logic                   dac_valid,
  input  logic                   dac_ready,
  output logic                   underflow,
  output logic [7:0]             overrun_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [11:0]      mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [11:0]      code_q, code_d;
  logic             vld_q, vld_d;
  logic             unf_q, unf_d;
  logic [7:0]       ovr_q, ovr_d;
  logic             tick, take, push, pop, ramp;

`ifdef DAC_FEEDER_RAMP_TEST_EN
  assign ramp = ramp_mode;
`else
  assign ramp = 1'b0;
`endif

  // '>=' rather than '==' so lowering rate_div below the running count
  // still yields a tick and wraps the counter instead of running to 2^DIV_W.
  assign tick  = (cnt_q >= rate_div);
  // A tick may load a new sample when nothing is pending or the pending one
  // is being taken in this same cycle.
  assign take  = tick && (!vld_q || dac_ready);
  assign full  = (lvl_q == LW'(DEPTH));
  assign empty = (lvl_q == '0);
  // Push is qualified on the pre-pop full flag; pop on the pre-push empty
  // flag, so a push into an empty FIFO on a tick still reports underflow.
  assign push  = wr_en && !full;
  assign pop   = take && !ramp && !empty;

  assign level       = lvl_q;
  assign dac_code    = code_q;
  assign dac_valid   = vld_q;
  assign underflow   = unf_q;
  assign overrun_cnt = ovr_q;

  // Next-state for divider, FIFO pointers/level and output handshake.
  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + DIV_W'(1);
    wp_d   = push ? wp_q + AW'(1) : wp_q;
    rp_d   = pop  ? rp_q + AW'(1) : rp_q;
    lvl_d  = lvl_q + LW'(push) - LW'(pop);
    code_d = code_q;
    vld_d  = vld_q;
    unf_d  = unf_q;
    ovr_d  = ovr_q;
    if (take) begin
      vld_d = 1'b1;
      if (ramp)        code_d = code_q + 12'd1;
      else if (!empty) code_d = mem_q[rp_q];
      else             unf_d  = 1'b1;
    end else if (tick) begin
      // Tick while the previous sample is still pending: drop it and count.
      if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
    end else if (vld_q && dac_ready) begin
      vld_d = 1'b0;
    end
  end

  // Control state with asynchronous reset; reset discards all queued data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      lvl_q  <= '0;
      code_q <= 12'd0;
      vld_q  <= 1'b0;
      unf_q  <= 1'b0;
      ovr_q  <= 8'd0;
    end else begin
      cnt_q  <= cnt_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      lvl_q  <= lvl_d;
      code_q <= code_d;
      vld_q  <= vld_d;
      unf_q  <= unf_d;
      ovr_q  <= ovr_d;
    end
  end

  // Sample storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wr_data;
  end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Directed bench for dac_sample_feeder. Inputs change on the falling edge,
// outputs are checked on the falling edge (half a cycle after the active edge).
module tb_dac_sample_feeder;
  localparam int DEPTH = 16;
  localparam int DIV_W = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             wr_en = 1'b0;
  logic [11:0]      wr_data = 12'd0;
  logic [DIV_W-1:0] rate_div = '1;
  logic             dac_ready = 1'b0;
`ifdef DAC_FEEDER_RAMP_TEST_EN
  logic             ramp_mode = 1'b0;
`endif
  logic             full, empty, dac_valid, underflow;
  logic [LW-1:0]    level;
  logic [11:0]      dac_code;
  logic [7:0]       overrun_cnt;

  int n_run  = 0;
  int n_fail = 0;

  dac_sample_feeder #(.DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef DAC_FEEDER_RAMP_TEST_EN
    .ramp_mode   (ramp_mode),
`endif
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .rate_div    (rate_div),
    .dac_code    (dac_code),
    .dac_valid   (dac_valid),
    .dac_ready   (dac_ready),
    .underflow   (underflow),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at a falling edge with reset released; next rising edge is E1.
  task automatic do_reset(input logic [DIV_W-1:0] rd);
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0; dac_ready = 1'b0; rate_div = rd;
`ifdef DAC_FEEDER_RAMP_TEST_EN
    ramp_mode = 1'b0;
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Reset values before any clock edge
    #3;
    chk("rst_code",  32'(dac_code),    32'h000);
    chk("rst_valid", 32'(dac_valid),   32'd0);
    chk("rst_full",  32'(full),        32'd0);
    chk("rst_empty", 32'(empty),       32'd1);
    chk("rst_level", 32'(level),       32'd0);
    chk("rst_unf",   32'(underflow),   32'd0);
    chk("rst_ovr",   32'(overrun_cnt), 32'd0);

    // Two samples at rate_div=3: valid pulses after E4 and E8
    do_reset(16'd3);
    dac_ready = 1'b1; wr_en = 1'b1; wr_data = 12'h555;
    cyc(1); wr_data = 12'hAAA;
    cyc(1); wr_en = 1'b0;
    cyc(1);
    chk("r3_pre_valid", 32'(dac_valid), 32'd0);
    chk("r3_pre_level", 32'(level),     32'd2);
    cyc(1);
    chk("r3_s0_valid", 32'(dac_valid), 32'd1);
    chk("r3_s0_code",  32'(dac_code),  32'h555);
    chk("r3_s0_level", 32'(level),     32'd1);
    cyc(1);
    chk("r3_s0_drop",  32'(dac_valid), 32'd0);
    cyc(2);
    chk("r3_gap_valid", 32'(dac_valid), 32'd0);
    cyc(1);
    chk("r3_s1_valid", 32'(dac_valid), 32'd1);
    chk("r3_s1_code",  32'(dac_code),  32'hAAA);
    chk("r3_s1_level", 32'(level),     32'd0);

    // Overfill with no ticks: DEPTH kept, extras dropped, order preserved
    do_reset('1);
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_en = 1'b1; wr_data = 12'h100 + 12'(i);
      cyc(1);
    end
    wr_en = 1'b0;
    chk("ovf_full",  32'(full),  32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_empty", 32'(empty), 32'd0);
    rate_div = '0;
    cyc(1);
    rate_div = '1;
    chk("ovf_pop0_code",  32'(dac_code),  32'h100);
    chk("ovf_pop0_valid", 32'(dac_valid), 32'd1);
    chk("ovf_pop0_level", 32'(level),     32'd15);
    chk("ovf_pop0_full",  32'(full),      32'd0);
    dac_ready = 1'b1; rate_div = '0;
    cyc(1);
    rate_div = '1; dac_ready = 1'b0;
    chk("ovf_pop1_code",  32'(dac_code), 32'h101);
    chk("ovf_pop1_level", 32'(level),    32'd14);

    // Push into empty FIFO on a tick: underflow, word stays queued
    do_reset('0);
    dac_ready = 1'b1; wr_en = 1'b1; wr_data = 12'h321;
    cyc(1); wr_en = 1'b0;
    chk("pe_unf",   32'(underflow), 32'd1);
    chk("pe_level", 32'(level),     32'd1);
    chk("pe_code",  32'(dac_code),  32'h000);
    chk("pe_valid", 32'(dac_valid), 32'd1);
    cyc(1);
    chk("pe_pop_code",  32'(dac_code), 32'h321);
    chk("pe_pop_level", 32'(level),    32'd0);
    cyc(1);
    chk("pe_hold_code", 32'(dac_code),  32'h321);
    chk("pe_hold_unf",  32'(underflow), 32'd1);

    // Empty FIFO, every cycle a tick
    do_reset('0);
    dac_ready = 1'b1;
    cyc(3);
    chk("emp_unf",   32'(underflow), 32'd1);
    chk("emp_code",  32'(dac_code),  32'h000);
    chk("emp_valid", 32'(dac_valid), 32'd1);
    chk("emp_empty", 32'(empty),     32'd1);

    // Stalled serializer: overrun saturates, FIFO and code untouched
    do_reset('1);
    wr_en = 1'b1; wr_data = 12'h7A5;
    cyc(1); wr_data = 12'h0C3;
    cyc(1); wr_en = 1'b0; rate_div = '0;
    cyc(1);
    chk("ovr_load_code", 32'(dac_code),    32'h7A5);
    chk("ovr_load_cnt",  32'(overrun_cnt), 32'd0);
    cyc(300);
    chk("ovr_cnt",   32'(overrun_cnt), 32'd255);
    chk("ovr_level", 32'(level),       32'd1);
    chk("ovr_code",  32'(dac_code),    32'h7A5);
    chk("ovr_valid", 32'(dac_valid),   32'd1);
    chk("ovr_unf",   32'(underflow),   32'd0);

    // Asynchronous reset mid-stream with level=5 and a pending sample
    do_reset('1);
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 12'h040 + 12'(i);
      cyc(1);
    end
    wr_en = 1'b0; rate_div = '0;
    cyc(1);
    rate_div = '1;
    chk("ar_pre_level", 32'(level),     32'd5);
    chk("ar_pre_valid", 32'(dac_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("ar_code",  32'(dac_code),    32'h000);
    chk("ar_valid", 32'(dac_valid),   32'd0);
    chk("ar_full",  32'(full),        32'd0);
    chk("ar_empty", 32'(empty),       32'd1);
    chk("ar_level", 32'(level),       32'd0);
    chk("ar_unf",   32'(underflow),   32'd0);
    chk("ar_ovr",   32'(overrun_cnt), 32'd0);
    cyc(1);
    reset = 1'b1;
    cyc(2);
    chk("ar_post_level", 32'(level), 32'd0);

`ifdef DAC_FEEDER_RAMP_TEST_EN
    // Ramp mode from a preset code of 4094 wraps through 4095, 0, 1
    do_reset('1);
    wr_en = 1'b1; wr_data = 12'hFFE;
    cyc(1); wr_en = 1'b0; dac_ready = 1'b1; rate_div = '0;
    cyc(1);
    chk("rmp_preset", 32'(dac_code), 32'hFFE);
    ramp_mode = 1'b1;
    cyc(1);
    chk("rmp_4095", 32'(dac_code), 32'hFFF);
    cyc(1);
    chk("rmp_0", 32'(dac_code), 32'h000);
    cyc(1);
    chk("rmp_1",   32'(dac_code),  32'h001);
    chk("rmp_unf", 32'(underflow), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
